// File: rtl/dcmi_rr_gate.sv
// dcmi_rr_gate: round-robin DCMI gateway with burst limit, sync gap and pixel-clock divider
// Ports:
//   CLK, nRST        global clock, asynchronous active-low reset
//   MDATA -> DATA    data from the granted transmitter, passed straight through
//   DCLK, DCLKEN     divided pixel clock and its one-CLK beat strobe
//   DREQ -> DACK     per-transmitter request / acknowledge (one-hot grant & DREQ)
//   DSYNC            frame sync, high while the granted transmitter is acknowledged
//   GIDX, BUSY       index of current/last grant, high while a grant is held
module dcmi_rr_gate #(
    parameter int M = 4,
    parameter int DW = 8,
    parameter int DIV_BITS = 1,
    parameter int MAX_BURST = 0,
    parameter int GAP = 1,
    localparam int GW = M > 1 ? $clog2(M) : 1
) (
    input  logic          CLK,
    input  logic          nRST,
    output logic [DW-1:0] DATA,
    output logic          DSYNC,
    output logic          DCLK,
    input  logic [DW-1:0] MDATA,
    output logic          DCLKEN,
    input  logic [M-1:0]  DREQ,
    output logic [M-1:0]  DACK,
    output logic [GW-1:0] GIDX,
    output logic          BUSY
);
    localparam int CW = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1;
    localparam int NW = GAP > 0 ? $clog2(GAP + 1) : 1;
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;
    state_t              state_q;
    logic [DIV_BITS-1:0] div_q;
    logic [M-1:0]        grant_q;
    logic [GW-1:0]       gidx_q, ptr_q, pick_d, idx_d, nxt_ptr;
    logic [CW-1:0]       cnt_q;
    logic [NW-1:0]       gcnt_q;
    logic                busy_q, found_d, burst_end, gap_end;
    // first requester at or after ptr, wrapping modulo M
    always_comb begin
        found_d = 1'b0;
        pick_d = '0;
        idx_d = '0;
        for (int k = 0; k < M; k++) begin
            idx_d = GW'((int'(ptr_q) + k) % M);
            if (!found_d && DREQ[idx_d]) begin
                found_d = 1'b1;
                pick_d = idx_d;
            end
        end
    end
    assign nxt_ptr   = GW'((int'(gidx_q) + 1) % M);
    assign burst_end = (MAX_BURST != 0) && (int'(cnt_q) + 1 == MAX_BURST);
    assign gap_end   = int'(gcnt_q) + 1 == GAP;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            div_q <= div_q + 1'b1;
            if (DCLKEN) begin
                case (state_q)
                    S_IDLE: if (found_d) begin
                        grant_q <= M'(1) << pick_d;
                        gidx_q  <= pick_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_GRANT;
                    end
                    // the last beat of a limited burst is still transferred on the release edge
                    S_GRANT: if (!DREQ[gidx_q] || burst_end) begin
                        grant_q <= '0;
                        ptr_q   <= nxt_ptr;
                        gcnt_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= GAP > 0 ? S_GAP : S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    S_GAP: begin
                        gcnt_q <= gcnt_q + 1'b1;
                        if (gap_end) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
    assign DATA   = MDATA;
    assign DCLKEN = &div_q;
    assign DCLK   = div_q[DIV_BITS-1];
    // a dropped request removes DACK/DSYNC without waiting for a beat edge
    assign DACK   = grant_q & DREQ;
    assign DSYNC  = |DACK;
    assign GIDX   = gidx_q;
    assign BUSY   = busy_q;
endmodule

// File: tb/tb_dcmi_rr_gate.sv
// tb_dcmi_rr_gate: directed-vector bench for dcmi_rr_gate (limited and unlimited burst instances)
module tb_dcmi_rr_gate;
    logic        clk = 1'b0;
    logic        nrst0 = 1'b0, nrst1 = 1'b0;
    logic [11:0] mdata0 = '0, data0;
    logic [7:0]  mdata1 = '0, data1;
    logic [3:0]  dreq0 = '0, dreq1 = '0, dack0, dack1;
    logic [1:0]  gidx0, gidx1;
    logic        dsync0, dclk0, dclken0, busy0;
    logic        dsync1, dclk1, dclken1, busy1;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    dcmi_rr_gate #(.M(4), .DW(12), .DIV_BITS(2), .MAX_BURST(3), .GAP(1)) u0 (
        .CLK(clk), .nRST(nrst0), .DATA(data0), .DSYNC(dsync0), .DCLK(dclk0), .MDATA(mdata0),
        .DCLKEN(dclken0), .DREQ(dreq0), .DACK(dack0), .GIDX(gidx0), .BUSY(busy0)
    );

    dcmi_rr_gate #(.M(4), .DW(8), .DIV_BITS(1), .MAX_BURST(0), .GAP(1)) u1 (
        .CLK(clk), .nRST(nrst1), .DATA(data1), .DSYNC(dsync1), .DCLK(dclk1), .MDATA(mdata1),
        .DCLKEN(dclken1), .DREQ(dreq1), .DACK(dack1), .GIDX(gidx1), .BUSY(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next beat edge of u0
    task automatic next_beat0();
        int n = 0;
        while (!dclken0 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("beat0_wait", 32'(n < 16), 1);
        @(posedge clk); #1;
    endtask

    task automatic next_beat1();
        int n = 0;
        while (!dclken1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("beat1_wait", 32'(n < 16), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int held;
        // reset: outputs stay 0 even with every request raised
        dreq0 = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("rst_outs", {dclk0, dclken0, dack0, dsync0, busy0, gidx0}, 0);
        end
        dreq0 = '0;
        nrst0 = 1'b1;
        // DCLK toggles every 2 CLK, DCLKEN once every 4 CLK
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk("dclk", dclk0, 32'((k % 4) >= 2));
            chk("dclken", dclken0, 32'((k % 4) == 3));
        end
        // round robin with burst 3 and a two-beat sync gap
        dreq0 = 4'b1111;
        next_beat0();
        for (int g = 0; g < 5; g++) begin
            chk("rr_gidx", gidx0, g % 4);
            chk("rr_dack", dack0, 1 << (g % 4));
            chk("rr_busy", busy0, 1);
            if (g == 4) break;
            next_beat0(); chk("rr_beat1", dsync0, 1);
            next_beat0(); chk("rr_beat2", dsync0, 1);
            next_beat0(); chk("rr_rel", {dsync0, busy0}, 0);
            next_beat0(); chk("rr_gap", {dsync0, busy0}, 0);
            next_beat0();
        end
        // reset mid-grant with cnt=2
        next_beat0(); next_beat0();
        chk("mid_busy", busy0, 1);
        @(posedge clk); #1;
        nrst0 = 1'b0;
        #1;
        chk("mid_rst_dack", dack0, 0);
        chk("mid_rst_sync_busy", {dsync0, busy0}, 0);
        chk("mid_rst_gidx", gidx0, 0);
        dreq0 = 4'b1010;
        @(posedge clk); @(posedge clk); #1;
        nrst0 = 1'b1;
        next_beat0();
        chk("post_rst_gidx", gidx0, 1);
        chk("post_rst_dack", dack0, 4'b0010);
        // basic grant and combinational drop
        dreq0 = '0;
        next_beat0(); next_beat0();
        chk("idle_busy", busy0, 0);
        dreq0 = 4'b0100;
        mdata0 = 12'h5A3;
        next_beat0();
        chk("bg_gidx", gidx0, 2);
        chk("bg_dack", dack0, 4'b0100);
        chk("bg_sync_busy", {dsync0, busy0}, 2'b11);
        chk("bg_data", data0, 12'h5A3);
        @(posedge clk); #1;
        dreq0 = '0;
        #1;
        chk("drop_dack", dack0, 0);
        chk("drop_sync_busy", {dsync0, busy0}, 2'b01);
        next_beat0();
        chk("drop_busy", busy0, 0);
        // data width pass-through while idle
        mdata0 = 12'hA5C;
        #1;
        chk("width_data", data0, 12'hA5C);
        // unlimited burst on u1
        dreq1 = 4'b1010;
        mdata1 = 8'h3C;
        @(posedge clk); #1;
        nrst1 = 1'b1;
        next_beat1();
        chk("ub_gidx", gidx1, 1);
        chk("ub_dack", dack1, 4'b0010);
        chk("ub_data", data1, 8'h3C);
        held = 0;
        for (int i = 0; i < 100; i++) begin
            next_beat1();
            if (dack1 == 4'b0010 && busy1) held++;
        end
        chk("ub_held", held, 100);
        dreq1 = 4'b1000;
        #1;
        chk("ub_drop_dack", dack1, 0);
        next_beat1(); chk("ub_rel", {dsync1, busy1}, 0);
        next_beat1(); chk("ub_gap", {dsync1, busy1}, 0);
        next_beat1();
        chk("ub_next_gidx", gidx1, 3);
        chk("ub_next_dack", dack1, 4'b1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
